// File: rtl/data_mem_stage.sv
// MEM-stage data memory: word loads/stores with a fixed multi-cycle latency and pipeline stall.
// Optional MEM_STAGE_ALIGN_CHECK_EN suppresses misaligned accesses and raises misalignMEM.
module data_mem_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] aluResultMEM,
  input  logic [31:0] regReadData2MEM,
  input  logic        memReadMEM,
  input  logic        memWriteMEM,
  output logic [31:0] memReadDataMEM,
  output logic        memStall,
  output logic        memDone
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  ,
  output logic        misalignMEM
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] LAST     = CW'(LATENCY - 1);
  localparam logic [CW-1:0] PRE_LAST = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic            r_is_store;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_req;
  logic            w_misalign;
  logic            w_accept;
  logic            w_last;
  logic            w_enter_final;
  logic            w_load_now;
  logic            w_in_store;
  logic [AW-1:0]   w_in_idx;
  logic [AW-1:0]   w_rd_idx;
  logic            w_unused;

  assign w_req      = memReadMEM | memWriteMEM;
  assign w_in_store = memWriteMEM;
  assign w_in_idx   = aluResultMEM[AW+1:2];
  assign w_unused   = ^{aluResultMEM[31:AW+2], aluResultMEM[1:0]};

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign w_misalign = w_req && (aluResultMEM[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && w_req && !w_misalign;
  assign w_last   = (r_state == BUSY) && (r_cnt == LAST);

  // The final cycle is entered straight from IDLE when LATENCY is 1, so the
  // load must then use the live address rather than the latched one.
  assign w_enter_final = (LATENCY == 1) ? w_accept
                                        : ((r_state == BUSY) && (r_cnt == PRE_LAST));
  assign w_load_now    = w_enter_final &&
                         ((r_state == IDLE) ? !w_in_store : !r_is_store);
  assign w_rd_idx      = (r_state == IDLE) ? w_in_idx : r_idx;

  assign memStall       = !rst && ((r_state == IDLE) ? w_accept : !w_last);
  assign memDone        = !rst && w_last;
  assign memReadDataMEM = r_rdata;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign misalignMEM    = !rst && (r_state == IDLE) && w_misalign;
`endif

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_is_store <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx      <= w_in_idx;
            r_wdata    <= regReadData2MEM;
            r_is_store <= w_in_store;
            r_cnt      <= '0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
      if (w_load_now) r_rdata <= r_mem[w_rd_idx];
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; contents stay undefined until written.
  always_ff @(posedge clk) begin
    if (!rst && w_last && r_is_store) r_mem[r_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage: directed spec scenarios plus random accesses
// against a word-array reference model.
module tb_data_mem_stage;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aluResultMEM;
  logic [31:0] regReadData2MEM;
  logic        memReadMEM;
  logic        memWriteMEM;
  logic [31:0] memReadDataMEM;
  logic        memStall;
  logic        memDone;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic        misalignMEM;
`endif

  data_mem_stage #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .aluResultMEM    (aluResultMEM),
    .regReadData2MEM (regReadData2MEM),
    .memReadMEM      (memReadMEM),
    .memWriteMEM     (memWriteMEM),
    .memReadDataMEM  (memReadDataMEM),
    .memStall        (memStall),
    .memDone         (memDone)
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    ,
    .misalignMEM     (misalignMEM)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  int          known_q [$];
  logic [31:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  // One complete access: LAT+1 MEM cycles; inputs are scrambled once BUSY
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data);
    int idx = word_of(addr);
    aluResultMEM    = addr;
    regReadData2MEM = data;
    memReadMEM      = rd;
    memWriteMEM     = wr;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      check("stall", 32'(memStall), 32'(k < LAT));
      check("done", 32'(memDone), 32'(k == LAT));
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      check("misalign_quiet", 32'(misalignMEM), 32'd0);
`endif
      if (k == LAT && rd && !wr) m_rdata = m_mem[idx];
      check("rdata", memReadDataMEM, m_rdata);
      @(posedge clk);
      #1;
      if (k == 0) begin
        aluResultMEM    = $urandom;
        regReadData2MEM = $urandom;
        memReadMEM      = 1'($urandom);
        memWriteMEM     = 1'($urandom);
      end
    end
    if (wr) begin
      m_mem[idx] = data;
      if (!m_known[idx]) known_q.push_back(idx);
      m_known[idx] = 1'b1;
    end
  endtask

  task automatic idle_cycle();
    memReadMEM  = 1'b0;
    memWriteMEM = 1'b0;
    @(negedge clk);
    check("idle_stall", 32'(memStall), 32'd0);
    check("idle_done", 32'(memDone), 32'd0);
    check("idle_rdata", memReadDataMEM, m_rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    int          pick;
    m_rdata         = '0;
    rst             = 1'b1;
    aluResultMEM    = 32'h10;
    regReadData2MEM = 32'hFFFF_FFFF;
    memReadMEM      = 1'b1;
    memWriteMEM     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(memStall), 32'd0);
    check("rst_done", 32'(memDone), 32'd0);
    check("rst_rdata", memReadDataMEM, 32'd0);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    check("rst_misalign", 32'(misalignMEM), 32'd0);
`endif
    memReadMEM  = 1'b0;
    memWriteMEM = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycle();

    // Store then immediate load, back to back
    access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h10, 32'h0);
    check("load_deadbeef", m_rdata, 32'hDEAD_BEEF);

    // Address wrap modulo DEPTH*4
    access(1'b0, 1'b1, 32'h0, 32'h1234_5678);
    access(1'b1, 1'b0, 32'h400, 32'h0);
    check("wrap_value", memReadDataMEM, 32'h1234_5678);

    // Read+write together behaves as a store; load data untouched
    access(1'b1, 1'b1, 32'h8, 32'h5A5A_5A5A);
    access(1'b1, 1'b0, 32'h8, 32'h0);

    // Reset in the first BUSY cycle of a store aborts it
    access(1'b0, 1'b1, 32'h20, 32'h1111_2222);
    aluResultMEM    = 32'h20;
    regReadData2MEM = 32'hAAAA_5555;
    memReadMEM      = 1'b0;
    memWriteMEM     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_stall", 32'(memStall), 32'd0);
    check("midrst_done", 32'(memDone), 32'd0);
    @(posedge clk);
    #1;
    m_rdata = '0;
    @(negedge clk);
    check("midrst_rdata", memReadDataMEM, 32'd0);
    memWriteMEM = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycle();
    access(1'b1, 1'b0, 32'h20, 32'h0);
    check("aborted_store", memReadDataMEM, 32'h1111_2222);

    // Misaligned store to 0x6
    access(1'b0, 1'b1, 32'h4, 32'hC0DE_0004);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    aluResultMEM    = 32'h6;
    regReadData2MEM = 32'hBAD0_BAD0;
    memReadMEM      = 1'b0;
    memWriteMEM     = 1'b1;
    @(negedge clk);
    check("mis_flag", 32'(misalignMEM), 32'd1);
    check("mis_stall", 32'(memStall), 32'd0);
    check("mis_done", 32'(memDone), 32'd0);
    @(posedge clk);
    #1;
    idle_cycle();
`else
    access(1'b0, 1'b1, 32'h6, 32'hBAD0_BAD0);
`endif
    access(1'b1, 1'b0, 32'h4, 32'h0);
    idle_cycle();

    // Random traffic: stores anywhere, loads only from written words
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        a = $urandom & 32'hFFFF_FFFC;
        access(1'($urandom), 1'b1, a, $urandom);
      end else begin
        pick = known_q[$urandom_range(known_q.size() - 1, 0)];
        a    = ($urandom & 32'hFFFF_FC00) | (32'(pick) << 2);
        access(1'b1, 1'b0, a, $urandom);
      end
      if ($urandom_range(3, 0) == 0) idle_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_stage.md
# data_mem_stage

Multi-cycle data-memory access unit for the MEM stage of the 5-stage pipeline. It consumes the EX/MEM pipeline register outputs (ALU result as address, second register operand as store data, and the memRead/memWrite controls) and performs word loads and stores against an internal word array with a fixed access latency. While an access is in progress it drives a stall back to the pipeline, and it presents load data to MEM/WB on the cycle the stall releases.

## Interface
- DEPTH_WORDS, 256: data array size in 32-bit words; power of two, ≥4.
- LATENCY, 2: access latency in cycles; ≥1.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- aluResultMEM  in  32  byte address of the access
- regReadData2MEM  in  32  store data
- memReadMEM  in  1  load request
- memWriteMEM  in  1  store request
- memReadDataMEM  out  32  load result, registered
- memStall  out  1  hold IF/ID/EX/EX-MEM registers and bubble MEM/WB
- memDone  out  1  high in the final cycle of an access
- misalignMEM  out  1  misaligned-access flag; present only with MEM_STAGE_ALIGN_CHECK_EN

## Operation
- States: IDLE, BUSY. The counter cnt has width clog2(LATENCY)+1.
- req = memReadMEM | memWriteMEM. A store wins if both are asserted: no load data update.
- IDLE, req=0: memStall=0, no action.
- IDLE, req=1: memStall=1 combinationally.
  - On the clock edge, latch the address index, store data and op. Go to BUSY with cnt=0.
- BUSY: memStall = (cnt != LATENCY-1), and cnt increments each edge.
  - The final cycle is cnt==LATENCY-1. In that cycle memStall=0 and memDone=1.
  - At the edge ending the final cycle: a store writes the array, and the FSM returns to IDLE.
- The pipeline advances at the edge ending the final cycle, so the next instruction's inputs are seen in IDLE. This prevents re-triggering the same access.
- Load data: memReadDataMEM is loaded with array[latched index] on the edge entering the final cycle, and holds its value otherwise.
- Array index = address[clog2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS×4.
- Inputs are ignored while in BUSY. The latched copies are used.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values:
  - State IDLE, cnt=0.
  - memReadDataMEM=0.
  - memStall=0 and memDone=0 while rst=1, regardless of the request inputs.
  - misalignMEM=0.
- Each access occupies LATENCY+1 MEM-stage cycles with LATENCY stall cycles. Example: LATENCY=2 gives 3 cycles and 2 stalls.
- Load data is valid during the memDone cycle and after it, until the next load's final-cycle edge.
- A store is visible to a load whose access starts in the cycle after memDone.
- Back-to-back accesses are allowed: an IDLE cycle with req=1 immediately follows the final cycle, with no idle gap required.
- Reset mid-access: return to IDLE next edge. A pending store is not committed, and memReadDataMEM is cleared to 0.

## Configuration
- MEM_STAGE_ALIGN_CHECK_EN defined:
  - In IDLE with req=1 and aluResultMEM[1:0]≠0, the access is suppressed: memStall=0, misalignMEM=1 for that cycle.
  - No state change, no array write, memReadDataMEM unchanged.
- Undefined: the misalignMEM port is absent, and address bits [1:0] are ignored (access proceeds on the word).

## Test plan
- Reset, then store 0xDEADBEEF to address 0x10 with LATENCY=2 → memStall=1 for 2 cycles, memDone=1 in cycle 3, and the array word 4 is written at the end of cycle 3.
- Load from 0x10 immediately after that store → memStall 2 cycles, memReadDataMEM=0xDEADBEEF in the memDone cycle.
- Store 0x12345678 at 0x0, then load from 0x400 with DEPTH_WORDS=256 → wraps to word 0, returning 0x12345678.
- Assert rst in the first BUSY cycle of a store of 0xAAAA5555 to 0x20, then load 0x20 → the aborted store left the word unchanged. After reset, memReadDataMEM=0 and memStall=0.
- memReadMEM=memWriteMEM=1, address 0x8, data 0x5A5A5A5A → treated as a store. memReadDataMEM is unchanged, and a later load of 0x8 returns 0x5A5A5A5A.
- With MEM_STAGE_ALIGN_CHECK_EN, store to 0x6 → misalignMEM=1 for one cycle, no stall, and a later load of 0x4 returns its prior value. Without the macro, the same store writes word 1.
